// File: rtl/uart_tx_core_if.sv
// Shared UART control register view: the field layout of uart_control_0 and the
// interface that carries it to the transmit and receive engines.
package uart_csr_pkg;
    localparam logic UART_PARITY = 1'b1;

    typedef struct packed {
        logic [3:0] data_bits;
        logic       parity_bit;
    } uart_control_0_csr_t;
endpackage

interface UART_csr_if;
    import uart_csr_pkg::*;

    uart_control_0_csr_t uart_control_0_csr;

    modport uart_mp (input  uart_control_0_csr);
    modport csr_mp  (output uart_control_0_csr);
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional even parity, stop.
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_start,
    output logic        tx_ready,
    output logic        tx,
    output logic        tx_done,
    UART_csr_if.uart_mp csr
);
    import uart_csr_pkg::*;

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_TC = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE_S   = 3'd0,
        START_S  = 3'd1,
        DATA_S   = 3'd2,
        PARITY_S = 3'd3,
        STOP_S   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic [3:0]    len, len_next;
    logic          par_en, par_en_next;
    logic          par, par_next;
    logic          tx_next;
    logic          done_next;
    logic          bit_end;
    logic          accept;
    logic [3:0]    cfg_len;
    logic [7:0]    cfg_mask;
    logic [2:0]    last_bit;

    assign tx_ready = (state == IDLE_S);
    assign accept   = tx_start && tx_ready;
    assign bit_end  = (timer == TIMER_TC);
    assign last_bit = 3'(len - 4'd1);

    always_comb begin
        cfg_len = csr.uart_control_0_csr.data_bits;
        if (cfg_len < 4'd5) begin
            cfg_len = 4'd5;
        end else if (cfg_len > 4'd8) begin
            cfg_len = 4'd8;
        end
        cfg_mask = 8'hFF >> (4'd8 - cfg_len);
    end

    always_comb begin
        state_next   = state;
        timer_next   = bit_end ? '0 : timer + 1'b1;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        len_next     = len;
        par_en_next  = par_en;
        par_next     = par;
        done_next    = 1'b0;

        case (state)
            IDLE_S: begin
                timer_next = '0;
                if (accept) begin
                    state_next   = START_S;
                    bit_cnt_next = '0;
                    shift_next   = tx_data & cfg_mask;
                    len_next     = cfg_len;
                    par_en_next  = (csr.uart_control_0_csr.parity_bit == UART_PARITY);
                    par_next     = ^(tx_data & cfg_mask);
                end
            end
            START_S: begin
                if (bit_end) state_next = DATA_S;
            end
            DATA_S: begin
                if (bit_end) begin
                    shift_next   = {1'b0, shift[7:1]};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == last_bit) begin
                        // counter is reused to count stop bits
                        bit_cnt_next = '0;
                        state_next   = par_en ? PARITY_S : STOP_S;
                    end
                end
            end
            PARITY_S: begin
                if (bit_end) state_next = STOP_S;
            end
            STOP_S: begin
                if (bit_end) begin
`ifdef UART_TX_STOP2_EN
                    if (bit_cnt == 3'd0) begin
                        bit_cnt_next = 3'd1;
                    end else begin
                        state_next = IDLE_S;
                        done_next  = 1'b1;
                    end
`else
                    state_next = IDLE_S;
                    done_next  = 1'b1;
`endif
                end
            end
            default: begin
                state_next = IDLE_S;
                timer_next = '0;
            end
        endcase

        // tx is registered, so it is driven from the state being entered
        case (state_next)
            START_S:  tx_next = 1'b0;
            DATA_S:   tx_next = shift_next[0];
            PARITY_S: tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE_S;
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            len     <= 4'd8;
            par_en  <= 1'b0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            len     <= len_next;
            par_en  <= par_en_next;
            par     <= par_next;
            tx      <= tx_next;
            tx_done <= done_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frames are predicted from the framing rules
// (start, clamped data bits LSB first, even parity, stop bits) and checked cycle by cycle.
module tb_uart_tx_core;
    localparam int C = 4;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       tx_done;

    int vectors     = 0;
    int miscompares = 0;

    UART_csr_if csr_if ();

    uart_tx_core #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_done  (tx_done),
        .csr      (csr_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int eff_bits(input int cfg);
        return (cfg < 5) ? 5 : ((cfg > 8) ? 8 : cfg);
    endfunction

    // Sends one frame (unless already accepted) and checks every cycle of it.
    // mid_cfg >= 0 rewrites the CSR (and flips parity) partway through the frame.
    task automatic send_and_check_frame(input logic [7:0] data, input int cfg, input bit par_on,
                                        input bit hold, input logic [7:0] next_data,
                                        input bit noise, input bit skip_accept, input int mid_cfg);
        bit exp_q[$];
        int d;
        int ones;
        int len;
        d    = eff_bits(cfg);
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < d; i++) begin
            exp_q.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (par_on) exp_q.push_back((ones % 2) == 1);
        for (int i = 0; i < STOP_BITS; i++) exp_q.push_back(1'b1);
        len = exp_q.size() * C;

        if (!skip_accept) begin
            csr_if.uart_control_0_csr.data_bits  = cfg[3:0];
            csr_if.uart_control_0_csr.parity_bit = par_on;
            tx_data  = data;
            tx_start = 1'b1;
            vectors++;
            if (tx_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL accept_ready: tx_ready=%b required 1", tx_ready);
            end
        end

        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            vectors++;
            if (tx !== exp_q[(k - 1) / C]) begin
                miscompares++;
                $display("FAIL frame_tx data=%h cycle=%0d: tx=%b required %b", data, k, tx, exp_q[(k - 1) / C]);
            end
            vectors++;
            if (tx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL frame_ready data=%h cycle=%0d: tx_ready=%b required 0", data, k, tx_ready);
            end
            vectors++;
            if (tx_done !== 1'b0) begin
                miscompares++;
                $display("FAIL frame_done data=%h cycle=%0d: tx_done=%b required 0", data, k, tx_done);
            end
            if (k == 1 || k == len) begin
                tx_start = hold;
                tx_data  = next_data;
            end else if (noise) begin
                tx_start = 1'($urandom_range(0, 1));
                tx_data  = 8'($urandom);
            end
            if (mid_cfg >= 0 && k == 3 * C) begin
                csr_if.uart_control_0_csr.data_bits  = mid_cfg[3:0];
                csr_if.uart_control_0_csr.parity_bit = ~par_on;
            end
        end

        @(negedge clk);
        vectors++;
        if (tx_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse data=%h: tx_done=%b required 1 at cycle %0d", data, tx_done, len + 1);
        end
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL done_ready data=%h: tx_ready=%b required 1", data, tx_ready);
        end
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL done_idle data=%h: tx=%b required 1", data, tx);
        end
    endtask

    task automatic test_reset();
        csr_if.uart_control_0_csr.data_bits  = 4'd8;
        csr_if.uart_control_0_csr.parity_bit = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cycle=%0d: tx=%b ready=%b done=%b required 1 1 0", i, tx, tx_ready, tx_done);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release cycle=%0d: tx=%b ready=%b done=%b required 1 1 0", i, tx, tx_ready, tx_done);
            end
        end
        // start request while in reset must not be accepted
        rst_n    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        rst_n    = 1'b1;
        tx_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_wins: tx=%b ready=%b required 1 1", tx, tx_ready);
        end
    endtask

    task automatic test_8n1();
        send_and_check_frame(8'hA5, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1);
    endtask

    task automatic test_parity();
        send_and_check_frame(8'hA5, 8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, -1);
        send_and_check_frame(8'h87, 7, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        send_and_check_frame(8'h55, 8, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, -1);
        send_and_check_frame(8'h0F, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, -1);
    endtask

    task automatic test_clamp_csr();
        send_and_check_frame(8'hFF, 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, -1);
        send_and_check_frame(8'hFF, 12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, -1);
        send_and_check_frame(8'hC3, 8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            int         cfg;
            bit         p;
            int         mid;
            d   = 8'($urandom);
            cfg = $urandom_range(0, 15);
            p   = 1'($urandom_range(0, 1));
            mid = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : -1;
            send_and_check_frame(d, cfg, p, 1'b0, 8'h00, 1'b1, 1'b0, mid);
        end
    endtask

    task automatic test_mid_reset();
        csr_if.uart_control_0_csr.data_bits  = 4'd8;
        csr_if.uart_control_0_csr.parity_bit = 1'b0;
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        for (int k = 1; k <= 4 * C + 2; k++) begin
            @(negedge clk);
            if (k == 1) tx_start = 1'b0;
        end
        vectors++;
        if (tx !== 1'b0 || tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_bit3: tx=%b ready=%b required 0 0", tx, tx_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1 || tx_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_abandon: tx=%b done=%b required 1 0", tx, tx_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_idle cycle=%0d: tx=%b ready=%b done=%b required 1 1 0", i, tx, tx_ready, tx_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_clamp_csr();
        test_random();
        test_mid_reset();
        test_8n1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART transmitter: serialises one parallel character per handshake into a standard asynchronous frame on `tx`. The frame is start bit, 5–8 data bits LSB first, optional even parity, then stop bit. It is the transmit counterpart of the receive FSM and shares its CSR interface (`UART_csr_if`), so one control register configures both directions. The block sits between the CSR/bus side, which pushes characters, and the `tx` pad.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Legal range ≥ 2.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  character to send; bits above the configured data width are ignored.
- `tx_start`  in  1  request/valid; a character is accepted on a cycle with `tx_start && tx_ready`.
- `tx_ready`  out  1  high only in IDLE_S; block can accept a character.
- `tx`  out  1  serial line, registered, idle high.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.
- `csr`  modport `UART_csr_if.uart_mp`. Uses `uart_control_0_csr.data_bits` (number of data bits) and `uart_control_0_csr.parity_bit`; parity is enabled when `parity_bit == UART_PARITY`.

## Operation
- States: IDLE_S, START_S, DATA_S, PARITY_S, STOP_S.
- IDLE_S
  - `tx=1`, `tx_ready=1`.
  - On accept: latch `tx_data` into the shift register, latch `data_bits` and parity enable, clear the bit timer and bit counter, go to START_S.
- START_S: `tx=0` for `CLKS_PER_BIT` cycles, then DATA_S.
- DATA_S
  - `tx` = shift register bit 0.
  - At the end of each bit period: shift right, increment the bit counter.
  - After the latched number of data bits: go to PARITY_S if parity is enabled, else STOP_S.
- PARITY_S: `tx` = even parity, i.e. XOR of the transmitted data bits only, for one bit period, then STOP_S.
- STOP_S: `tx=1` for one stop period, then IDLE_S with a `tx_done` pulse.
- Bit timer
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1; bit-period end is at terminal count.
- Bit counter: 3 bits, counts 0..7, reset at each accept.
- `data_bits` handling: latched value below 5 clamps to 5; above 8 clamps to 8.
- CSR changes during a frame have no effect until the next accept.
- `tx_start` outside IDLE_S is ignored. No buffering; the requester holds `tx_start` until it sees `tx_ready`.
- Illegal state encoding: next state is IDLE_S, `tx=1`.

## Timing
- Reset values: state IDLE_S, `tx=1`, `tx_ready=1`, `tx_done=0`, timer 0, counter 0, shift register 0.
- Reset mid-frame:
  - On the cycle after `rst_n` is sampled low, `tx=1` and the frame is abandoned.
  - No `tx_done` is produced.
- Accept at edge N: `tx` falls low starting cycle N+1; `tx_ready` is low from N+1.
- Every bit is exactly `CLKS_PER_BIT` cycles on `tx`.
- Frame length is (1 + D + P + 1)·`CLKS_PER_BIT` cycles, where D = data bits and P = parity enable.
- `tx_done` is high for exactly one cycle: the first cycle back in IDLE_S, simultaneous with `tx_ready=1`.
- Back-to-back frames:
  - An accept in the `tx_done` cycle starts the next start bit on the following cycle.
  - The minimum inter-frame idle is one cycle.
- `tx_start` and `rst_n` low in the same cycle: reset wins, nothing is accepted.

## Configuration
- `UART_TX_STOP2_EN`
  - Defined: STOP_S lasts 2·`CLKS_PER_BIT` cycles (two stop bits), and the frame length formula uses +2 stop bits.
  - Undefined: one stop bit of `CLKS_PER_BIT` cycles.
  - No other behaviour changes.

## Test plan
- Reset: assert `rst_n=0` for 3 cycles, release. Required: `tx=1`, `tx_ready=1`, `tx_done=0` throughout, no edge on `tx`.
- 8N1 frame: `CLKS_PER_BIT=4`, `data_bits=8`, no parity, send 0xA5.
  - Required `tx` bits: 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
  - Frame is 40 cycles; `tx_done` appears on cycle 41 after the accept.
- Parity frames:
  - 8E1 with 0xA5: parity bit 0, frame 44 cycles.
  - 7E1 with 0x87: upper bit ignored, data 0000111 LSB first, parity bit 1.
- Back-to-back: hold `tx_start=1` with 0x55 then 0x0F. Required: second start bit begins 1 cycle after `tx_done`, no glitch; `tx_start` pulses mid-frame do not corrupt the frame.
- Clamp and CSR stability:
  - `data_bits=3` sends 5 data bits.
  - Changing `data_bits` from 8 to 5 mid-frame still sends 8 bits for the current frame.
- Reset mid-frame: assert `rst_n=0` during DATA_S bit 3. Required: `tx=1` next cycle, `tx_ready=1` after release, no `tx_done`. With `UART_TX_STOP2_EN` defined, 8N1 0xA5 gives a 44-cycle frame.
